// File: rtl/box_blur_stream.sv
`default_nettype none
// ============================================================================
// Module   : box_blur_stream
// Brief    : Streaming per-frame bypass / 3x3 / 5x5 mean filter on packed
//            multi-channel pixels with valid/ready/SOP/EOP links.
// Revision : 1.0 - initial release
// ============================================================================
module box_blur_stream #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int BPC      = 4,
    parameter int CHANNELS = 3,
    parameter int KMAX     = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic                    startofpacket_in,
    input  logic                    endofpacket_in,
    input  logic [CHANNELS*BPC-1:0] data_in,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic                    startofpacket_out,
    output logic                    endofpacket_out,
    output logic [CHANNELS*BPC-1:0] data_out,
    output logic                    frame_err
);

    localparam int DW    = CHANNELS * BPC;
    localparam int HK    = KMAX / 2;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int DLY   = HK * IMG_W + HK;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam int S_W   = BPC + $clog2(KMAX * KMAX);

    localparam logic [CNT_W-1:0] c_NPIX_M1  = CNT_W'(NPIX - 1);
    localparam logic [CNT_W-1:0] c_DLY      = CNT_W'(DLY);
    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [31:0]      c_RECIP3   = 32'd7282;
    localparam logic [31:0]      c_RECIP5   = 32'd2621;
    localparam logic [31:0]      c_ROUND    = 32'd32768;
    localparam logic [31:0]      c_PIX_MAX  = 32'((1 << BPC) - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;

    logic [1:0]       r_state, w_state_nxt;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_in_cnt, r_out_cnt;
    logic [ROW_W-1:0] r_out_row;
    logic [COL_W-1:0] r_out_col;
    logic [COL_W-1:0] r_lb_ptr;
    logic             r_valid_out, r_sop_out, r_eop_out, r_frame_err;
    logic [DW-1:0]    r_data_out;

    logic w_advance, w_ready, w_acc, w_sop, w_data_beat, w_flush_adv;
    logic w_shift, w_produce, w_last, w_err;
    logic w_border3, w_border5, w_use5, w_bypass;

    logic [DW-1:0] w_pix, w_pix_out;
    logic [DW-1:0] w_tap    [KMAX];
    logic [DW-1:0] w_lb_out [KMAX-1];
    logic [DW-1:0] r_win    [KMAX][KMAX];
    logic [DW-1:0] w_nwin   [KMAX][KMAX];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_sop) w_state_nxt = S_STREAM;
            S_STREAM: if (w_last) w_state_nxt = S_FLUSH;
            S_FLUSH:  if (w_flush_adv && (r_out_cnt == c_NPIX_M1)) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    always_comb begin
        w_advance   = !r_valid_out || ready_in;
        w_ready     = w_advance && (r_state != S_FLUSH) && rst_n;
        w_acc       = valid_in && w_ready;
        w_sop       = w_acc && startofpacket_in;
        w_data_beat = w_acc && (w_sop || (r_state == S_STREAM));
        w_flush_adv = (r_state == S_FLUSH) && w_advance;
        w_shift     = w_data_beat || w_flush_adv;
        // A SOP beat is pixel 0 of a frame, which never yields an output itself.
        w_produce   = (w_data_beat && !w_sop && (r_in_cnt >= c_DLY)) || w_flush_adv;
        w_last      = (r_state == S_STREAM) && w_acc && !startofpacket_in
                      && (r_in_cnt == c_NPIX_M1);
        w_err       = (r_state == S_STREAM) && w_acc
                      && (startofpacket_in || (endofpacket_in != (r_in_cnt == c_NPIX_M1)));
    end

    assign ready_out         = w_ready;
    assign valid_out         = r_valid_out;
    assign startofpacket_out = r_sop_out;
    assign endofpacket_out   = r_eop_out;
    assign data_out          = r_data_out;
    assign frame_err         = r_frame_err;

    // ---------------- counters and output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= 2'd0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_lb_ptr    <= '0;
            r_valid_out <= 1'b0;
            r_sop_out   <= 1'b0;
            r_eop_out   <= 1'b0;
            r_data_out  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            if (w_sop) begin
                r_mode   <= mode;
                r_in_cnt <= CNT_W'(1);
            end else if (w_data_beat) begin
                r_in_cnt <= r_in_cnt + 1'b1;
            end
            if (w_sop) begin
                r_out_cnt <= '0;
                r_out_row <= '0;
                r_out_col <= '0;
            end else if (w_produce) begin
                r_out_cnt <= r_out_cnt + 1'b1;
                if (r_out_col == c_COL_LAST) begin
                    r_out_col <= '0;
                    r_out_row <= (r_out_row == c_ROW_LAST) ? '0 : r_out_row + 1'b1;
                end else begin
                    r_out_col <= r_out_col + 1'b1;
                end
            end
            if (w_shift)
                r_lb_ptr <= (r_lb_ptr == c_COL_LAST) ? '0 : r_lb_ptr + 1'b1;
            if (w_advance) begin
                r_valid_out <= w_produce;
                r_sop_out   <= w_produce && (r_out_cnt == '0);
                r_eop_out   <= w_produce && (r_out_cnt == c_NPIX_M1);
            end
            if (w_produce)
                r_data_out <= w_pix_out;
        end
    end

    // ---------------- line buffers and window ----------------
    assign w_pix = (r_state == S_FLUSH) ? '0 : data_in;

    for (genvar j = 0; j < KMAX - 1; j++) begin : g_lb
        logic [DW-1:0] r_mem [IMG_W];
        logic [DW-1:0] w_in;
        if (j == 0) begin : g_first
            assign w_in = w_pix;
        end else begin : g_chain
            assign w_in = w_lb_out[j-1];
        end
        always_ff @(posedge clk) begin
            if (w_shift) r_mem[r_lb_ptr] <= w_in;
        end
        assign w_lb_out[j] = r_mem[r_lb_ptr];
    end

    for (genvar r = 0; r < KMAX; r++) begin : g_tap
        if (r == KMAX - 1) begin : g_newest
            assign w_tap[r] = w_pix;
        end else begin : g_delayed
            assign w_tap[r] = w_lb_out[KMAX-2-r];
        end
    end

    // The filter works on the window as it will look after this shift.
    always_comb begin
        for (int r = 0; r < KMAX; r++) begin
            for (int c = 0; c < KMAX - 1; c++)
                w_nwin[r][c] = r_win[r][c+1];
            w_nwin[r][KMAX-1] = w_tap[r];
        end
    end

    always_ff @(posedge clk) begin
        if (w_shift) begin
            for (int r = 0; r < KMAX; r++)
                for (int c = 0; c < KMAX; c++)
                    r_win[r][c] <= w_nwin[r][c];
        end
    end

    // ---------------- border and filter ----------------
    assign w_bypass  = (r_mode == 2'd0);
    assign w_use5    = r_mode[1] && (KMAX >= 5);
    assign w_border3 = (r_out_row < ROW_W'(1)) || (r_out_row >= ROW_W'(IMG_H - 1))
                    || (r_out_col < COL_W'(1)) || (r_out_col >= COL_W'(IMG_W - 1));
    assign w_border5 = (r_out_row < ROW_W'(2)) || (r_out_row >= ROW_W'(IMG_H - 2))
                    || (r_out_col < COL_W'(2)) || (r_out_col >= COL_W'(IMG_W - 2));

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        localparam int LSB = (CHANNELS - 1 - ch) * BPC;
        logic [S_W-1:0] w_s3, w_s5;
        logic [31:0]    w_q3, w_q5;
        logic [BPC-1:0] w_cen, w_b3, w_b5, w_res;

        always_comb begin
            w_s3 = '0;
            w_s5 = '0;
            for (int r = 0; r < KMAX; r++) begin
                for (int c = 0; c < KMAX; c++) begin
                    if ((r >= HK - 2) && (r <= HK + 2) && (c >= HK - 2) && (c <= HK + 2))
                        w_s5 = w_s5 + S_W'(w_nwin[r][c][LSB +: BPC]);
                    if ((r >= HK - 1) && (r <= HK + 1) && (c >= HK - 1) && (c <= HK + 1))
                        w_s3 = w_s3 + S_W'(w_nwin[r][c][LSB +: BPC]);
                end
            end
            w_q3  = (32'(w_s3) * c_RECIP3 + c_ROUND) >> 16;
            w_q5  = (32'(w_s5) * c_RECIP5 + c_ROUND) >> 16;
            w_b3  = (w_q3 > c_PIX_MAX) ? c_PIX_MAX[BPC-1:0] : w_q3[BPC-1:0];
            w_b5  = (w_q5 > c_PIX_MAX) ? c_PIX_MAX[BPC-1:0] : w_q5[BPC-1:0];
            w_cen = w_nwin[HK][HK][LSB +: BPC];
            if (w_bypass)    w_res = w_cen;
            else if (w_use5) w_res = w_border5 ? w_cen : w_b5;
            else             w_res = w_border3 ? w_cen : w_b3;
        end

        assign w_pix_out[LSB +: BPC] = w_res;
    end

endmodule
`default_nettype wire

// File: tb/tb_box_blur_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_box_blur_stream
// Brief    : Directed self-checking bench for box_blur_stream on a reduced
//            8x6 frame (KMAX=5, latency 18 beats).
// Revision : 1.0 - initial release
// ============================================================================
module tb_box_blur_stream;

    localparam int TW = 8;
    localparam int TH = 6;
    localparam int TK = 5;
    localparam int TN = TW * TH;
    localparam int TD = (TK / 2) * TW + TK / 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        startofpacket_in = 1'b0;
    logic        endofpacket_in = 1'b0;
    logic [11:0] data_in = 12'h000;
    logic        valid_out;
    logic        ready_in = 1'b1;
    logic        startofpacket_out;
    logic        endofpacket_out;
    logic [11:0] data_out;
    logic        frame_err;

    box_blur_stream #(
        .IMG_W(TW), .IMG_H(TH), .BPC(4), .CHANNELS(3), .KMAX(TK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .valid_in(valid_in), .ready_out(ready_out),
        .startofpacket_in(startofpacket_in), .endofpacket_in(endofpacket_in),
        .data_in(data_in),
        .valid_out(valid_out), .ready_in(ready_in),
        .startofpacket_out(startofpacket_out), .endofpacket_out(endofpacket_out),
        .data_out(data_out), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0;
    int err_cnt = 0, stall_bad = 0, to_cnt = 0;
    int first_vcyc = -1, acc_d_cyc = -2;
    bit rdy_rand = 1'b0;
    logic prev_stall = 1'b0;
    logic [11:0] prev_data = 12'h000;

    logic [11:0] frame [TN];
    logic [11:0] out_d [$];
    bit          out_s [$];
    bit          out_e [$];

    always @(posedge clk) cyc = cyc + 1;

    // Downstream model: drives ready_in, records transfers, watches stall stability.
    always @(negedge clk) begin
        ready_in = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        #1;
        if (frame_err) err_cnt++;
        if (prev_stall && rst_n && (!valid_out || data_out !== prev_data)) stall_bad++;
        if (valid_out && first_vcyc < 0) first_vcyc = cyc;
        if (valid_out && ready_in) begin
            out_d.push_back(data_out);
            out_s.push_back(startofpacket_out);
            out_e.push_back(endofpacket_out);
        end
        prev_stall = rst_n && valid_out && !ready_in;
        prev_data  = data_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] gold(input int k, input logic [1:0] m);
        int r, c, h, s;
        logic [11:0] res;
        r = k / TW;
        c = k % TW;
        h = (m == 2'd0) ? 0 : (m == 2'd1) ? 1 : 2;
        if (h == 0 || r < h || r >= TH - h || c < h || c >= TW - h) return frame[k];
        res = 12'h000;
        for (int ch = 0; ch < 3; ch++) begin
            s = 0;
            for (int dr = -h; dr <= h; dr++)
                for (int dc = -h; dc <= h; dc++)
                    s += int'((frame[(r + dr) * TW + c + dc] >> (8 - 4 * ch)) & 12'h00F);
            s = (s * ((h == 1) ? 7282 : 2621) + 32768) >> 16;
            if (s > 15) s = 15;
            res[11 - 4 * ch -: 4] = 4'(s);
        end
        return res;
    endfunction

    task automatic send_frame(input int n, input logic [1:0] m, input bit eop_ok, input int gap_max);
        int g;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(negedge clk);
                valid_in = 1'b0;
            end
            @(negedge clk);
            valid_in         = 1'b1;
            data_in          = frame[i];
            startofpacket_in = (i == 0);
            endofpacket_in   = eop_ok && (i == TN - 1);
            mode             = (i == 0) ? m : 2'($urandom_range(0, 3));
            #1;
            g = 0;
            while (!ready_out && g < 200) begin
                @(negedge clk);
                #1;
                g++;
            end
            if (g >= 200) to_cnt++;
            if (i == TD) acc_d_cyc = cyc + 1;
        end
        @(negedge clk);
        valid_in         = 1'b0;
        startofpacket_in = 1'b0;
        endofpacket_in   = 1'b0;
    endtask

    task automatic clear_out();
        out_d.delete();
        out_s.delete();
        out_e.delete();
        err_cnt = 0;
    endtask

    task automatic wait_out(input string tag, input int n);
        int g = 0;
        while (out_d.size() < n && g < 3000) begin
            @(negedge clk);
            g++;
        end
        repeat (30) @(negedge clk);
        chk({tag, "_count"}, out_d.size(), n);
    endtask

    task automatic check_frame(input string tag, input logic [1:0] m);
        int ns = 0, ne = 0;
        wait_out(tag, TN);
        if (out_d.size() >= TN) begin
            for (int k = 0; k < TN; k++) begin
                chk($sformatf("%s_pix%0d", tag, k), out_d[k], gold(k, m));
                ns += int'(out_s[k]);
                ne += int'(out_e[k]);
            end
            chk({tag, "_sop_first"}, out_s[0], 1);
            chk({tag, "_eop_last"}, out_e[TN-1], 1);
            chk({tag, "_sop_total"}, ns, 1);
            chk({tag, "_eop_total"}, ne, 1);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", valid_out, 0);
        chk("rst_ready", ready_out, 0);
        chk("rst_sop", startofpacket_out, 0);
        chk("rst_eop", endofpacket_out, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_data", data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Flat frame through 5x5: every pixel must come back unchanged
        for (int k = 0; k < TN; k++) frame[k] = 12'hA5C;
        clear_out();
        send_frame(TN, 2'd2, 1'b1, 0);
        check_frame("flat", 2'd2);
        chk("flat_hand_first", out_d[0], 12'hA5C);
        chk("flat_hand_mid", out_d[3 * TW + 3], 12'hA5C);
        chk("flat_err", err_cnt, 0);

        // Impulse 0xF00 at (3,4): 3x3 neighbourhood -> 0x200, rest 0
        for (int k = 0; k < TN; k++) frame[k] = 12'h000;
        frame[3 * TW + 4] = 12'hF00;
        clear_out();
        send_frame(TN, 2'd1, 1'b1, 0);
        wait_out("imp3", TN);
        for (int k = 0; k < TN && k < out_d.size(); k++)
            chk($sformatf("imp3_pix%0d", k), out_d[k],
                ((k / TW) >= 2 && (k / TW) <= 4 && (k % TW) >= 3 && (k % TW) <= 5) ? 12'h200 : 12'h000);

        // 5x5 -> 0x100 on interior pixels (rows 2..3, cols 2..5) within reach
        clear_out();
        send_frame(TN, 2'd2, 1'b1, 0);
        wait_out("imp5", TN);
        for (int k = 0; k < TN && k < out_d.size(); k++)
            chk($sformatf("imp5_pix%0d", k), out_d[k],
                ((k / TW) >= 2 && (k / TW) <= 3 && (k % TW) >= 2 && (k % TW) <= 5) ? 12'h100 : 12'h000);

        // Random frame in bypass, plus first-output latency
        for (int k = 0; k < TN; k++) frame[k] = 12'($urandom);
        clear_out();
        first_vcyc = -1;
        acc_d_cyc  = -2;
        send_frame(TN, 2'd0, 1'b1, 0);
        check_frame("byp", 2'd0);
        chk("byp_latency", first_vcyc, acc_d_cyc);

        // Random backpressure and input gaps, 5x5 then 3x3
        rdy_rand  = 1'b1;
        stall_bad = 0;
        for (int k = 0; k < TN; k++) frame[k] = 12'($urandom);
        clear_out();
        send_frame(TN, 2'd3, 1'b1, 3);
        check_frame("bp5", 2'd3);
        for (int k = 0; k < TN; k++) frame[k] = 12'($urandom);
        clear_out();
        send_frame(TN, 2'd1, 1'b1, 3);
        check_frame("bp3", 2'd1);
        chk("bp_stall_stable", stall_bad, 0);
        rdy_rand = 1'b0;
        repeat (4) @(negedge clk);

        // SOP injected at input pixel 20: two outputs already out, then resync
        for (int k = 0; k < TN; k++) frame[k] = 12'($urandom);
        clear_out();
        send_frame(20, 2'd1, 1'b1, 0);
        repeat (5) @(negedge clk);
        chk("trunc_outs", out_d.size(), 20 - TD);
        chk("trunc_sop", out_s[0], 1);
        clear_out();
        send_frame(TN, 2'd1, 1'b1, 0);
        check_frame("resync", 2'd1);
        chk("resync_err", err_cnt, 1);

        // Missing EOP on the last beat
        clear_out();
        send_frame(TN, 2'd2, 1'b0, 0);
        check_frame("noeop", 2'd2);
        chk("noeop_err", err_cnt, 1);

        // Reset in the middle of a frame, then a clean frame
        for (int k = 0; k < TN; k++) frame[k] = 12'($urandom);
        send_frame(30, 2'd2, 1'b1, 0);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("midrst_valid", valid_out, 0);
            chk("midrst_ready", ready_out, 0);
            chk("midrst_data", data_out, 0);
            chk("midrst_eop", endofpacket_out, 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_out();
        send_frame(TN, 2'd1, 1'b1, 2);
        check_frame("postrst", 2'd1);
        chk("postrst_err", err_cnt, 0);

        chk("accept_timeouts", to_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
